// File: rtl/mdu_issue_ctrl.sv
// Issue sequencer for the shared multi-cycle multiply/divide unit and the HI/LO pair.
// Starts the MDU, counts its latency, strobes HI/LO write-back and requests ID stalls.
module mdu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_mdu_req,
  input  logic [1:0] id_mdu_op,
  input  logic       id_div_zero,
  input  logic       id_hilo_use,
  input  logic       flush,
  output logic       mdu_start,
  output logic [1:0] mdu_op,
  output logic       mdu_sel_div,
  output logic       hilo_we,
  output logic       busy,
  output logic       stall_req
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Counter is loaded with LAT-1 so BUSY spans exactly LAT cycles.
  localparam logic [CNT_W-1:0] MulCnt = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DivCnt = CNT_W'(DIV_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             start_q, start_d;
  logic             issue;

  assign issue = (state_q == StIdle) && id_mdu_req && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          start_d = 1'b1;
          op_d    = id_mdu_op;
          if (id_mdu_op[1] && id_div_zero) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            cnt_d   = id_mdu_op[1] ? DivCnt : MulCnt;
          end
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      start_q <= start_d;
    end
  end

  assign mdu_start   = start_q;
  assign mdu_op      = op_q;
  assign mdu_sel_div = op_q[1];
  assign busy        = (state_q != StIdle);
  assign hilo_we     = (state_q == StDone);
  // No HI/LO forwarding, so the DONE cycle must stall dependents as well.
  assign stall_req   = busy && (id_mdu_req || id_hilo_use);

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Sequences the shared multi-cycle multiply/divide unit (MDU) and the HI/LO register pair in the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu from the ID stage and starts the MDU. Counts its latency and generates the HI/LO write strobe.
- Raises a stall request to the hazard logic, which deasserts PC_write and IF_ID_write, while a later MDU or HI/LO instruction sits in ID and the unit is busy.

Parameters:
- MUL_LAT, 4, MDU cycles for mult/multu; legal range 1..2^CNT_W.
- DIV_LAT, 32, MDU cycles for div/divu; legal range 1..2^CNT_W.
- CNT_W, 6, latency counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- id_mdu_req  input  1  instruction in ID is mult/multu/div/divu.
- id_mdu_op  input  2  00 mult, 01 multu, 10 div, 11 divu; valid with id_mdu_req.
- id_div_zero  input  1  divisor operand is zero; valid with id_mdu_req and a div op.
- id_hilo_use  input  1  instruction in ID is mfhi/mflo/mthi/mtlo.
- flush  input  1  ID instruction is being squashed this cycle (branch/load-use flush).
- mdu_start  output  1  one-cycle start pulse to the MDU datapath.
- mdu_op  output  2  latched operation for the MDU; held stable while busy.
- mdu_sel_div  output  1  mdu_op[1], registered.
- hilo_we  output  1  one-cycle HI/LO write enable.
- busy  output  1  state != IDLE.
- stall_req  output  1  combinational; ORed into the PC_write/IF_ID_write deassert and ID/EX bubble insertion.

Behaviour:
- States: IDLE, BUSY, DONE. State and counter are registered. All outputs are 0 on reset; mdu_op resets to 00.
- Issue condition, evaluated in cycle T: state==IDLE, id_mdu_req=1 and flush=0.
- On issue:
  - At T+1: mdu_start=1 for exactly one cycle; mdu_op and mdu_sel_div are loaded.
  - Normal path: state goes to BUSY with cnt = LAT-1. LAT is DIV_LAT if id_mdu_op[1], else MUL_LAT.
  - If id_mdu_op[1] and id_div_zero: state goes directly to DONE at T+1 (early termination; HI/LO contents are architecturally undefined).
- BUSY:
  - cnt decrements by 1 per cycle.
  - When cnt==0, next state is DONE. BUSY therefore lasts exactly LAT cycles (T+1..T+LAT).
  - The counter never wraps below 0.
- DONE:
  - hilo_we=1 for one cycle.
  - The next state is IDLE unconditionally. No issue is accepted from DONE; a new request waits one cycle.
- stall_req = busy & (id_mdu_req | id_hilo_use). It is also asserted in DONE, because HI/LO are written at the end of that cycle and there is no HI/LO forwarding.
- Only the first instruction issues directly from IDLE. A second MDU op following back-to-back is stalled until IDLE.
- flush:
  - Suppresses issue in IDLE.
  - Does not cancel an operation already issued; that instruction has left ID and is committed.
  - While busy, flush has no effect on state.
- stall_req has no effect on state (the controller itself never waits on the stall).
- Simultaneous id_mdu_req and id_hilo_use are decoder-illegal; treat them as id_mdu_req.
- Reset mid-operation: next cycle is IDLE with cnt=0. hilo_we is never asserted for the aborted op; the MDU result is discarded.
- mdu_op holds its last value in IDLE.

Test Plan:
- Reset: hold rst for 3 cycles with random inputs → all outputs 0 and state IDLE from the first post-reset edge.
- mult issue, defaults:
  - Stimulus: id_mdu_req=1, op=00 at cycle 10 only.
  - Required: mdu_start=1 at 11 only; busy=1 cycles 11–15; hilo_we=1 at 15 only; busy=0 at 16.
- div with dependent mflo:
  - Stimulus: op=10 issued at 10; id_hilo_use=1 from cycle 11.
  - Required: stall_req=1 cycles 11–43; hilo_we=1 at 43; stall_req=0 at 44.
- Divide by zero:
  - Stimulus: op=11 with id_div_zero=1 at 10.
  - Required: mdu_start and DONE at 11; hilo_we=1 at 11; busy=0 at 12.
- Back-to-back and flush cases:
  - Flush: id_mdu_req=1 with flush=1 at 10 → no mdu_start.
  - Back-to-back: mult at 10, a second mult held in ID → stall_req=1 cycles 11–15; the second issues at 16 with mdu_start=1 at 17.
- Reset mid-divide:
  - Stimulus: div issued at 10; rst=1 at 20.
  - Required: IDLE at 21; hilo_we stays 0 through cycle 50; a new mult issued at 22 completes normally with hilo_we=1 at 27.
